lfsr_rng: RTL and testbench
===========================

// Module: lfsr_rng
// PURPOSE
//  Parametrised Fibonacci LFSR random-number source with a request/valid handshake and range limiting.
//  Register free-runs while enabled; on request, collects WIDTH fresh shifts, rejection-samples against LIMIT, returns an OUT_W-bit word.
//  Feeds game logic (e.g. pipe gap height) that needs a bounded value on demand; replaces ad-hoc fixed 13-bit LFSRs.
// PARAMETERS
//  WIDTH      13       LFSR state width (2..32)
//  TAPS       13'h100D feedback mask; bit i set => state[i] XORed into feedback (default x^13+x^4+x^3+x+1, maximal, period 8191)
//  SEED       13'h000F reset/recovery state; must be non-zero
//  OUT_W      8        output word width, OUT_W <= WIDTH
//  LIMIT      8'd200   largest acceptable output value
//  MAX_RETRY  3        rejection retries before clamping
// PORTS
//  clock       in   1      system clock
//  reset       in   1      asynchronous, active-high reset
//  enable      in   1      free-run shift enable while IDLE
//  seed_load   in   1      load seed_value into state this cycle
//  seed_value  in   WIDTH  seed to load; 0 is replaced by SEED
//  req         in   1      request a new word (sampled in IDLE only)
//  busy        out  1      high in COLLECT/CHECK
//  valid       out  1      one-cycle pulse: rnd updated
//  rnd         out  OUT_W  last delivered word, held stable until next valid
//  state_out   out  WIDTH  raw LFSR state (debug)
// BEHAVIOUR
//  Reset (async, active-high): state=SEED, fsm=IDLE, count=0, retry=0, rnd=0, valid=0, busy=0.
//  Shift: state <= {state[WIDTH-2:0], ^(state & TAPS)}; one shift per cycle.
//  Shift occurs: IDLE when enable=1; COLLECT always (enable ignored).
//  seed_load: priority over shift in any state; state <= (seed_value==0 ? SEED : seed_value); fsm/count unaffected.
//  Lock-up guard: if state==0 at a clock edge (only via corruption), state <= SEED instead of shifting.
//  FSM:
//   IDLE    -- req=1 -> COLLECT, count=0, retry=0. req while busy ignored (no queueing).
//   COLLECT -- shift each cycle, count++; after WIDTH shifts (count==WIDTH-1 edge) -> CHECK.
//   CHECK   -- cand = state[OUT_W-1:0].
//              cand<=LIMIT: rnd<=cand, valid=1 next cycle, -> IDLE.
//              cand>LIMIT && retry<MAX_RETRY: retry++, count=0, -> COLLECT.
//              cand>LIMIT && retry==MAX_RETRY: rnd<=LIMIT (clamp), valid=1, -> IDLE.
//  Latency req->valid: WIDTH+2 cycles best case; (MAX_RETRY+1)*(WIDTH+1)+1 worst case.
//  valid exactly one cycle; busy=1 from cycle after req until the cycle valid asserts (busy=0 with valid).
//  req in same cycle valid pulses (fsm back in IDLE) is accepted.
//  seed_load during COLLECT: collection continues from the new state; count not reset.
//  Reset mid-operation: abandons request, no valid; rnd returns to 0.
//  count width clog2(WIDTH+1), retry width clog2(MAX_RETRY+1); no arithmetic overflow possible.
// STRUCTURE
//  Package game_rng_pkg: rng_state_e enum {IDLE, COLLECT, CHECK}; default TAPS/SEED constants for widths 8,13,16.
//  Sub-module lfsr_core (WIDTH, TAPS, SEED): state register, shift, seed_load, zero guard; lfsr_rng adds FSM, counters, range check, output register.
// TESTING
//  Reset then enable=1, 2 cycles: state_out 0x000F -> 0x001F -> 0x003F; rnd=0, valid=0.
//  Free-run enable=1 for 8191 cycles from SEED: state returns to 0x000F, never 0 in between, no earlier repeat.
//  enable=0, req pulse: busy high 14 cycles, valid pulses at cycle 15, rnd == golden model value <= 200.
//  LIMIT=8'd10, MAX_RETRY=0, seed chosen so cand>10: rnd=10 clamped, valid once after WIDTH+2 cycles.
//  seed_load with seed_value=0: state_out=0x000F next cycle; seed_load with 0x1234 mid-COLLECT: result matches model from 0x1234.
//  Assert reset during COLLECT: busy/valid drop immediately, rnd=0; new req after release completes normally.

Source files
------------

// File: rtl/game_rng_pkg.sv
// Shared types and default LFSR constants for the game random-number source.
// The default tap masks are maximal-length for a left-shifting Fibonacci register.
package game_rng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } rng_state_e;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [7:0]  SEED_W8  = 8'h0F;
  localparam logic [12:0] TAPS_W13 = 13'h100D;
  localparam logic [12:0] SEED_W13 = 13'h000F;
  localparam logic [15:0] TAPS_W16 = 16'hD008;
  localparam logic [15:0] SEED_W16 = 16'h000F;

  function automatic logic [31:0] default_taps(input int width);
    case (width)
      8:       return 32'(TAPS_W8);
      16:      return 32'(TAPS_W16);
      default: return 32'(TAPS_W13);
    endcase
  endfunction

  function automatic logic [31:0] default_seed(input int width);
    case (width)
      8:       return 32'(SEED_W8);
      16:      return 32'(SEED_W16);
      default: return 32'(SEED_W13);
    endcase
  endfunction

  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed loading and an all-zero recovery guard.
// Shifts left, feeding the parity of the tapped bits into bit 0.
module lfsr_core
  import game_rng_pkg::*;
#(
  parameter int               WIDTH = 13,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(default_seed(WIDTH))
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             feedback;

  assign feedback = ^(state_q & TAPS);

  always_comb begin
    // NOTE: state_d is defaulted before the priority chain so no latch can be inferred.
    state_d = state_q;
    if (seed_load) begin
      state_d = (seed_value == '0) ? SEED : seed_value;
    end else if (state_q == '0) begin
      // All-zero is a dead state for an XOR LFSR; only corruption can get here.
      state_d = SEED;
    end else if (shift_en) begin
      state_d = {state_q[WIDTH-2:0], feedback};
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_rng.sv
// On-demand bounded random word: collects WIDTH fresh LFSR shifts per attempt,
// rejection-samples against LIMIT and clamps to LIMIT after MAX_RETRY retries.
module lfsr_rng
  import game_rng_pkg::*;
#(
  parameter int               WIDTH     = 13,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(default_seed(WIDTH)),
  parameter int               OUT_W     = 8,
  parameter logic [OUT_W-1:0] LIMIT     = 8'd200,
  parameter int               MAX_RETRY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] rnd,
  output logic [WIDTH-1:0] state_out
);

  localparam int CNT_W   = ctr_width(WIDTH);
  localparam int RETRY_W = ctr_width(MAX_RETRY);

  rng_state_e         fsm_q, fsm_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [OUT_W-1:0]   rnd_q, rnd_d;
  logic               valid_q, valid_d;

  logic [WIDTH-1:0]   lfsr_state;
  logic               shift_en;
  logic [OUT_W-1:0]   cand;
  logic               cand_ok;
  logic               collect_done;
  logic               retry_left;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .shift_en   (shift_en),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .state      (lfsr_state)
  );

  assign cand         = lfsr_state[OUT_W-1:0];
  assign cand_ok      = (cand <= LIMIT);
  assign collect_done = (count_q == CNT_W'(WIDTH - 1));
  // retry_q never passes MAX_RETRY, so inequality is enough.
  assign retry_left   = (retry_q != RETRY_W'(MAX_RETRY));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      count_q <= '0;
      retry_q <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      count_q <= count_d;
      retry_q <= retry_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (req) fsm_d = COLLECT;
      COLLECT: if (collect_done) fsm_d = CHECK;
      CHECK:   fsm_d = (!cand_ok && retry_left) ? COLLECT : IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    retry_d  = retry_q;
    rnd_d    = rnd_q;
    valid_d  = 1'b0;
    shift_en = 1'b0;
    case (fsm_q)
      IDLE: begin
        shift_en = enable;
        if (req) begin
          count_d = '0;
          retry_d = '0;
        end
      end
      COLLECT: begin
        shift_en = 1'b1;
        count_d  = count_q + CNT_W'(1);
      end
      CHECK: begin
        if (cand_ok) begin
          rnd_d   = cand;
          valid_d = 1'b1;
        end else if (retry_left) begin
          retry_d = retry_q + RETRY_W'(1);
          count_d = '0;
        end else begin
          rnd_d   = LIMIT;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (fsm_q != IDLE);
  assign valid     = valid_q;
  assign rnd       = rnd_q;
  assign state_out = lfsr_state;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: expected words and latencies are queued when a
// request is issued and compared when the DUT raises valid.
module tb_lfsr_rng;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        seed_load = 1'b0;
  logic [12:0] seed_value = '0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;

  logic        busy0, valid0, busy1, valid1;
  logic [7:0]  rnd0, rnd1;
  logic [12:0] state0, state1;

  always #5 clock = ~clock;

  lfsr_rng u_dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .req        (req0),
    .busy       (busy0),
    .valid      (valid0),
    .rnd        (rnd0),
    .state_out  (state0)
  );

  lfsr_rng #(
    .LIMIT     (8'd10),
    .MAX_RETRY (0)
  ) u_dut_clamp (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .req        (req1),
    .busy       (busy1),
    .valid      (valid1),
    .rnd        (rnd1),
    .state_out  (state1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rnd;
    int         cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [12:0] mdl_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] step(input logic [12:0] s);
    return {s[11:0], ^(s & 13'h100D)};
  endfunction

  // Reference: first attempt uses first_shifts shifts, later attempts a full 13.
  function automatic void model(input logic [12:0] s_in, input int first_shifts,
                                input logic [7:0] limit, input int max_retry,
                                output logic [7:0] res, output int attempts,
                                output bit clamped, output logic [12:0] s_out);
    logic [12:0] s;
    int          n;
    bit          done;
    s = s_in; n = first_shifts; attempts = 0; done = 0; res = '0; clamped = 0;
    for (int a = 0; a <= max_retry && !done; a++) begin
      for (int i = 0; i < n; i++) s = step(s);
      attempts++;
      n = 13;
      if (s[7:0] <= limit) begin
        res = s[7:0]; done = 1;
      end else if (a == max_retry) begin
        res = limit; clamped = 1; done = 1;
      end
    end
    s_out = s;
  endfunction

  // Entered and left at posedge+1. which=0 targets LIMIT=200/MAX_RETRY=3, which=1 LIMIT=10/MAX_RETRY=0.
  task automatic do_req(input int which, input bit load, input logic [12:0] seed,
                        input int load_at, input logic [12:0] load_val, input int extra_at);
    logic [12:0] s0, s_end;
    logic [7:0]  res, lim, got_rnd;
    int          att, mr, cycles, busy_cnt;
    bit          clamp, seen, busy_at_valid;
    exp_t        e;
    lim = (which == 0) ? 8'd200 : 8'd10;
    mr  = (which == 0) ? 3 : 0;
    if (load) begin
      seed_value = seed; seed_load = 1'b1;
      @(posedge clock); #1;
      seed_load = 1'b0;
      s0 = (seed == '0) ? 13'h000F : seed;
    end else begin
      s0 = mdl_state;
    end
    if (load_at > 0)
      model((load_val == '0) ? 13'h000F : load_val, 13 - load_at, lim, mr, res, att, clamp, s_end);
    else
      model(s0, 13, lim, mr, res, att, clamp, s_end);
    e.rnd = res; e.cycles = att * 14 + 1;
    exp_q.push_back(e);
    mdl_state = s_end;

    if (which == 0) req0 = 1'b1; else req1 = 1'b1;
    cycles = 0; busy_cnt = 0; seen = 0; busy_at_valid = 0; got_rnd = '0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge clock); #1;
      cycles++;
      req0 = 1'b0; req1 = 1'b0; seed_load = 1'b0;
      if (cycles == load_at) begin seed_value = load_val; seed_load = 1'b1; end
      if (cycles == extra_at) begin if (which == 0) req0 = 1'b1; else req1 = 1'b1; end
      if ((which == 0) ? valid0 : valid1) begin
        seen = 1;
        busy_at_valid = (which == 0) ? busy0 : busy1;
        got_rnd = (which == 0) ? rnd0 : rnd1;
      end else if ((which == 0) ? busy0 : busy1) begin
        busy_cnt++;
      end
    end

    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      if (!seen) begin
        check("valid_timeout", 0, 1);
      end else begin
        check("rnd_value", 32'(got_rnd), 32'(e.rnd));
        check("latency", cycles, e.cycles);
        check("busy_cycles", busy_cnt, e.cycles - 1);
        check("busy_with_valid", 32'(busy_at_valid), 0);
        check("rnd_in_range", 32'(got_rnd <= lim), 1);
      end
    end
  endtask

  task automatic quiet(input int which);
    @(posedge clock); #1;
    check("valid_one_cycle", 32'((which == 0) ? valid0 : valid1), 0);
    check("idle_after", 32'((which == 0) ? busy0 : busy1), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] s, so, retry_seed, clamp_seed, clamp1_seed;
    logic [7:0]  r;
    int          att, mism, zero_hits, first_rep;
    bit          cl;

    #22 reset = 1'b0;
    @(posedge clock); #1;
    check("reset_state", 32'(state0), 32'h000F);
    check("reset_rnd", 32'(rnd0), 0);
    check("reset_valid", 32'(valid0), 0);
    check("reset_busy", 32'(busy0), 0);

    enable = 1'b1;
    @(posedge clock); #1;
    check("shift1", 32'(state0), 32'h001F);
    @(posedge clock); #1;
    check("shift2", 32'(state0), 32'h003F);
    enable = 1'b0;
    check("freerun_no_valid", 32'(valid0), 0);

    seed_value = '0; seed_load = 1'b1;
    @(posedge clock); #1;
    seed_load = 1'b0;
    check("seed_zero_load", 32'(state0), 32'h000F);

    enable = 1'b1;
    s = 13'h000F; mism = 0; zero_hits = 0; first_rep = 0;
    for (int i = 1; i <= 8191; i++) begin
      @(posedge clock); #1;
      s = step(s);
      if (state0 !== s) mism++;
      if (state0 == '0) zero_hits++;
      if (state0 == 13'h000F && first_rep == 0) first_rep = i;
    end
    enable = 1'b0;
    check("period_trace", mism, 0);
    check("period_no_zero", zero_hits, 0);
    check("period_length", first_rep, 8191);
    check("period_final", 32'(state0), 32'h000F);

    retry_seed = '0; clamp_seed = '0; clamp1_seed = '0;
    for (int k = 1; k < 8192; k++) begin
      model(13'(k), 13, 8'd200, 3, r, att, cl, so);
      if (att == 2 && retry_seed == '0) retry_seed = 13'(k);
      if (cl && clamp_seed == '0) clamp_seed = 13'(k);
      model(13'(k), 13, 8'd10, 0, r, att, cl, so);
      if (cl && clamp1_seed == '0) clamp1_seed = 13'(k);
    end

    do_req(0, 1, 13'h0001, 0, '0, 0);         quiet(0);
    do_req(0, 1, 13'h1ABC, 0, '0, 3);         quiet(0);
    do_req(0, 1, 13'h0F0F, 0, '0, 0);
    do_req(0, 0, '0, 0, '0, 0);               quiet(0);
    do_req(0, 1, retry_seed, 0, '0, 0);       quiet(0);
    do_req(0, 1, clamp_seed, 0, '0, 0);       quiet(0);
    do_req(0, 1, 13'h0555, 5, 13'h1234, 0);   quiet(0);
    for (int k = 0; k < 3; k++) begin
      do_req(0, 1, 13'($urandom_range(1, 8191)), 0, '0, 0);
      quiet(0);
    end

    do_req(1, 1, clamp1_seed, 0, '0, 0);
    check("clamp_value", 32'(rnd1), 10);
    quiet(1);

    // Abandon a request with reset mid-collection.
    seed_value = 13'h0ABC; seed_load = 1'b1;
    @(posedge clock); #1;
    seed_load = 1'b0; req0 = 1'b1;
    @(posedge clock); #1;
    req0 = 1'b0;
    repeat (4) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy0), 0);
    check("rst_valid", 32'(valid0), 0);
    check("rst_rnd", 32'(rnd0), 0);
    check("rst_state", 32'(state0), 32'h000F);
    @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock); #1;
    mdl_state = 13'h000F;
    do_req(0, 0, '0, 0, '0, 0);
    quiet(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
